// File: rtl/dcf77_tx.sv
// -----------------------------------------------------------------------------
// dcf77_tx
// DCF77-format time-code transmitter. Each second starts with a carrier
// reduction of PULSE0_TICKS (bit 0) or PULSE1_TICKS (bit 1) clk_en ticks.
// Second 59 carries no pulse and marks the minute. The 59-bit frame is
// latched from the next_* inputs on the clk_en that moves the second counter
// from 59 to 0. The frame in flight is therefore immune to later input changes.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   clk_en           10 ms tick, one clk cycle wide
//   enable           1 = transmit, 0 = idle (counters held at idle values)
//   next_minute      BCD minute for the frame starting at the next mark
//   next_hour        BCD hour
//   next_day         BCD day of month
//   next_day_of_week 1 = Mon ... 7 = Sun
//   next_month       BCD month
//   next_year        BCD year
//   tx               1 = carrier reduced (pulse active), registered
//   second           binary second index 0..59 of the current frame, registered
//   minute_start     one-cycle strobe at the start of second 0, registered
// -----------------------------------------------------------------------------
module dcf77_tx #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned PULSE0_TICKS  = 10,
    parameter int unsigned PULSE1_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       enable,
    input  logic [7:0] next_minute,
    input  logic [7:0] next_hour,
    input  logic [7:0] next_day,
    input  logic [2:0] next_day_of_week,
    input  logic [7:0] next_month,
    input  logic [7:0] next_year,
    output logic       tx,
    output logic [5:0] second,
    output logic       minute_start
);

    localparam int unsigned    TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0]  TICK_MAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]     SEC_LAST = 6'd59;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [21:0] data);
        return ^data;
    endfunction

    // Assemble the 59-bit minute frame from the sampled time fields.
    function automatic logic [58:0] build_frame(
        input logic [7:0] minute,
        input logic [7:0] hour,
        input logic [7:0] day,
        input logic [2:0] dow,
        input logic [7:0] month,
        input logic [7:0] year
    );
        logic [58:0] f;
        f        = 59'd0;
        f[20]    = 1'b1;
        f[27:21] = minute[6:0];
        f[28]    = even_parity({15'd0, minute[6:0]});
        f[34:29] = hour[5:0];
        f[35]    = even_parity({16'd0, hour[5:0]});
        f[41:36] = day[5:0];
        f[44:42] = dow;
        f[49:45] = month[4:0];
        f[57:50] = year;
        f[58]    = even_parity({day[5:0], dow, month[4:0], year});
        return f;
    endfunction

    logic [TW-1:0] tick_r;
    logic [TW-1:0] tick_s;
    logic [5:0]    sec_r;
    logic [5:0]    sec_s;
    logic [58:0]   frame_r;
    logic [58:0]   frame_s;
    logic [58:0]   new_frame_s;
    logic          wrap_s;
    logic          bit_s;
    logic          tx_s;
    logic          tx_r;
    logic [5:0]    second_r;
    logic          minute_start_r;

    assign new_frame_s = build_frame(next_minute, next_hour, next_day,
                                     next_day_of_week, next_month, next_year);

    // Next-state computation for the tick/second counters and frame latch.
    always_comb begin
        tick_s  = tick_r;
        sec_s   = sec_r;
        frame_s = frame_r;
        wrap_s  = 1'b0;
        if (!enable) begin
            // Disable has priority over a coincident clk_en.
            tick_s = TICK_MAX;
            sec_s  = SEC_LAST;
        end else if (clk_en) begin
            if (tick_r == TICK_MAX) begin
                tick_s = {TW{1'b0}};
                if (sec_r == SEC_LAST) begin
                    sec_s   = 6'd0;
                    wrap_s  = 1'b1;
                    frame_s = new_frame_s;
                end else begin
                    sec_s = sec_r + 6'd1;
                end
            end else begin
                tick_s = tick_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            tick_s = tick_r;
        end
    end

    // Pulse decision from the next state so tx lands one cycle after clk_en.
    always_comb begin
        bit_s = 1'b0;
        tx_s  = 1'b0;
        if (sec_s < SEC_LAST) begin
            bit_s = frame_s[sec_s];
            if (bit_s) begin
                tx_s = (32'(tick_s) < PULSE1_TICKS);
            end else begin
                tx_s = (32'(tick_s) < PULSE0_TICKS);
            end
        end else begin
            // Second 59: no pulse marks the minute.
            tx_s = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r         <= TICK_MAX;
            sec_r          <= SEC_LAST;
            frame_r        <= 59'd0;
            tx_r           <= 1'b0;
            second_r       <= SEC_LAST;
            minute_start_r <= 1'b0;
        end else begin
            tick_r         <= tick_s;
            sec_r          <= sec_s;
            frame_r        <= frame_s;
            tx_r           <= tx_s;
            second_r       <= sec_s;
            minute_start_r <= wrap_s;
        end
    end

    assign tx           = tx_r;
    assign second       = second_r;
    assign minute_start = minute_start_r;

endmodule

// File: tb/tb_dcf77_tx.sv
// -----------------------------------------------------------------------------
// tb_dcf77_tx
// Directed bench for dcf77_tx with a shortened second: 20 ticks per second,
// 4/8-tick pulses, clk_en every 4 clk cycles. Pulse widths are measured in clk
// cycles (16 for a 0 bit, 32 for a 1 bit) and compared to hand-built frames.
// -----------------------------------------------------------------------------
module tb_dcf77_tx;

    localparam int TPS  = 20;
    localparam int P0   = 4;
    localparam int P1   = 8;
    localparam int DIV  = 4;
    localparam int SECC = TPS * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] next_minute = 8'h00;
    logic [7:0] next_hour = 8'h00;
    logic [7:0] next_day = 8'h01;
    logic [2:0] next_day_of_week = 3'd1;
    logic [7:0] next_month = 8'h01;
    logic [7:0] next_year = 8'h00;
    logic       tx;
    logic [5:0] second;
    logic       minute_start;

    int checks = 0;
    int failures = 0;
    int phase = 0;

    logic [58:0] exp1;
    logic [58:0] exp2;

    dcf77_tx #(
        .TICKS_PER_SEC(TPS),
        .PULSE0_TICKS (P0),
        .PULSE1_TICKS (P1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .enable          (enable),
        .next_minute     (next_minute),
        .next_hour       (next_hour),
        .next_day        (next_day),
        .next_day_of_week(next_day_of_week),
        .next_month      (next_month),
        .next_year       (next_year),
        .tx              (tx),
        .second          (second),
        .minute_start    (minute_start)
    );

    always #5 clk = ~clk;

    // One clk cycle; clk_en is high every DIV-th cycle. Outputs sampled #1 after the edge.
    task automatic step;
        @(negedge clk);
        clk_en = (phase == DIV - 1);
        phase  = (phase + 1) % DIV;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        checks++;
        if (tx !== 1'b0 || second !== 6'd59 || minute_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: tx=%b second=%0d ms=%b, want tx=0 second=59 ms=0",
                     tx, second, minute_start);
        end
        rst_n = 1'b1;
        repeat (9) step();
        checks++;
        if (tx !== 1'b0 || second !== 6'd59 || minute_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: tx=%b second=%0d ms=%b, want tx=0 second=59 ms=0",
                     tx, second, minute_start);
        end
    endtask

    task automatic test_first_second;
        bit found;
        found  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            if (minute_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            checks++;
            if (tx !== 1'b0 || second !== 6'd59) begin
                failures++;
                $display("FAIL pre_first_tick: tx=%b second=%0d, want tx=0 second=59", tx, second);
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL first_minute_start: strobe seen=0, want 1 within %0d cycles", 2 * DIV);
        end
        checks++;
        if (second !== 6'd0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL second0_start: second=%0d tx=%b, want second=0 tx=1", second, tx);
        end
    endtask

    // Entered positioned on the minute_start cycle; measures all 60 seconds.
    task automatic measure_frame(input logic [58:0] expf, input bit chg, input string tag);
        int cnt;
        int want;
        int extra_ms;
        extra_ms = 0;
        for (int s = 0; s < 60; s++) begin
            cnt = 0;
            for (int c = 0; c < SECC; c++) begin
                if (!(s == 0 && c == 0)) step();
                if (c == 0 && s == 30 && chg) next_minute = 8'h12;
                if (c == 0) begin
                    checks++;
                    if (second !== 6'(s)) begin
                        failures++;
                        $display("FAIL %s_second_index: got %0d, want %0d", tag, second, s);
                    end
                end
                if (tx === 1'b1) cnt++;
                if (minute_start === 1'b1 && !(s == 0 && c == 0)) extra_ms++;
            end
            want = (s == 59) ? 0 : (expf[s] ? P1 * DIV : P0 * DIV);
            checks++;
            if (cnt !== want) begin
                failures++;
                $display("FAIL %s_pulse_s%0d: high cycles=%0d, want %0d", tag, s, cnt, want);
            end
        end
        checks++;
        if (extra_ms !== 0) begin
            failures++;
            $display("FAIL %s_extra_strobe: got %0d extra minute_start, want 0", tag, extra_ms);
        end
    endtask

    task automatic test_frames;
        measure_frame(exp1, 1'b1, "frame1");
        step();
        checks++;
        if (minute_start !== 1'b1 || second !== 6'd0) begin
            failures++;
            $display("FAIL frame_period: ms=%b second=%0d after 60 s, want ms=1 second=0",
                     minute_start, second);
        end
        measure_frame(exp2, 1'b0, "frame2");
    endtask

    task automatic test_disable;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 * SECC; i++) begin
            step();
            if (second === 6'd3 && tx === 1'b1) break;
        end
        while (phase != DIV - 1) step();
        enable = 1'b0;
        step();   // clk_en coincides with the falling enable
        checks++;
        if (tx !== 1'b0 || second !== 6'd59 || minute_start !== 1'b0) begin
            failures++;
            $display("FAIL disable_wins: tx=%b second=%0d ms=%b, want tx=0 second=59 ms=0",
                     tx, second, minute_start);
        end
        repeat (12) step();
        checks++;
        if (tx !== 1'b0 || second !== 6'd59) begin
            failures++;
            $display("FAIL disabled_hold: tx=%b second=%0d, want tx=0 second=59", tx, second);
        end
        enable = 1'b1;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            if (minute_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || second !== 6'd0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL reenable: strobe=%b second=%0d tx=%b, want strobe=1 second=0 tx=1",
                     found, second, tx);
        end
    endtask

    task automatic test_async_reset;
        step();
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL pulse_before_reset: tx=%b, want 1", tx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b0 || second !== 6'd59) begin
            failures++;
            $display("FAIL async_reset: tx=%b second=%0d, want tx=0 second=59", tx, second);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Hand-encoded frame for 37 min, 14 h, day 25, Wednesday, month 12, year 24.
        exp1        = 59'd0;
        exp1[20]    = 1'b1;
        exp1[27:21] = 7'b0110111;
        exp1[28]    = 1'b1;
        exp1[34:29] = 6'b010100;
        exp1[35]    = 1'b0;
        exp1[41:36] = 6'b100101;
        exp1[44:42] = 3'b011;
        exp1[49:45] = 5'b10010;
        exp1[57:50] = 8'b00100100;
        exp1[58]    = 1'b1;
        // Same, but minute 12: bits 0,1,0,0,1,0,0 and P1 = 0.
        exp2        = exp1;
        exp2[27:21] = 7'b0010010;
        exp2[28]    = 1'b0;

        next_minute      = 8'h37;
        next_hour        = 8'h14;
        next_day         = 8'h25;
        next_day_of_week = 3'd3;
        next_month       = 8'h12;
        next_year        = 8'h24;

        test_reset();
        test_first_second();
        test_frames();
        test_disable();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
